// File: rtl/bram_arbiter.sv
// bram_arbiter: zero-fills a BRAM after reset, then shares it between two requesters with round-robin on conflicts
module bram_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_0,
   input  logic                  req_we_0,
   input  logic [ADDR_WIDTH-1:0] req_addr_0,
   input  logic [DATA_WIDTH-1:0] req_wdata_0,
   output logic                  req_ready_0,
   output logic                  rsp_valid_0,
   output logic [DATA_WIDTH-1:0] rsp_rdata_0,
   input  logic                  req_valid_1,
   input  logic                  req_we_1,
   input  logic [ADDR_WIDTH-1:0] req_addr_1,
   input  logic [DATA_WIDTH-1:0] req_wdata_1,
   output logic                  req_ready_1,
   output logic                  rsp_valid_1,
   output logic [DATA_WIDTH-1:0] rsp_rdata_1,
   output logic                  init_done,
   output logic                  mem_rst,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);
   typedef enum logic [1:0] {RST_HOLD, INIT, RUN} state_t;
   state_t state, state_nx;
   logic [ADDR_WIDTH:0] init_addr;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic prio, pend_0, pend_1;
   logic run, init_last, mixed, conflict, g0, g1, rd0, rd1, wr0, wr1;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= RST_HOLD;
         mem_rst   <= 1'b1;
         init_addr <= '0;
         prio      <= 1'b0;
         pend_0    <= 1'b0;
         pend_1    <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         state     <= state_nx;
         mem_rst   <= state_nx == RST_HOLD;
         init_addr <= state == INIT ? init_addr + 1'b1 : '0;
         if (conflict) prio <= ~prio;
         pend_0    <= rd0;
         pend_1    <= rd1;
         if (rd0 | rd1) rd_addr_q <= mem_rd_addr;
      end

   always_comb begin
      state_nx = state;
      state_nx = state == RST_HOLD ? INIT :
                 (state == INIT && init_last) ? RUN : state;
   end

   assign run       = state == RUN;
   assign init_last = init_addr == {1'b0, {ADDR_WIDTH{1'b1}}};
   // a reader and a writer never compete: each owns its own RAM port
   assign mixed     = req_valid_0 & req_valid_1 & (req_we_0 ^ req_we_1);
   assign conflict  = run & req_valid_0 & req_valid_1 & ~(req_we_0 ^ req_we_1);
   assign g0        = run & req_valid_0 & (~req_valid_1 | mixed | ~prio);
   assign g1        = run & req_valid_1 & (~req_valid_0 | mixed | prio);
   assign rd0       = g0 & ~req_we_0;
   assign rd1       = g1 & ~req_we_1;
   assign wr0       = g0 & req_we_0;
   assign wr1       = g1 & req_we_1;

   assign req_ready_0    = g0;
   assign req_ready_1    = g1;
   assign rsp_valid_0    = pend_0;
   assign rsp_valid_1    = pend_1;
   assign rsp_rdata_0    = mem_read_data;
   assign rsp_rdata_1    = mem_read_data;
   assign init_done      = run;
   assign mem_wr_en      = state == INIT | wr0 | wr1;
   assign mem_wr_addr    = state == INIT ? init_addr[ADDR_WIDTH-1:0] : wr1 ? req_addr_1 : req_addr_0;
   assign mem_write_data = wr1 ? req_wdata_1 : wr0 ? req_wdata_0 : '0;
   assign mem_rd_addr    = rd0 ? req_addr_0 : rd1 ? req_addr_1 : rd_addr_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: vector table plus scoreboard around bram_arbiter and a behavioural BRAM
module tb_bram_arbiter;
   logic clk, rst;
   logic req_valid_0, req_we_0, req_ready_0, rsp_valid_0;
   logic req_valid_1, req_we_1, req_ready_1, rsp_valid_1;
   logic [3:0] req_addr_0, req_addr_1, mem_wr_addr, mem_rd_addr;
   logic [7:0] req_wdata_0, req_wdata_1, rsp_rdata_0, rsp_rdata_1;
   logic init_done, mem_rst, mem_wr_en;
   logic [7:0] mem_write_data, mem_read_data;
   logic [7:0] ram [16];
   logic [7:0] ref_mem [16];
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int checks = 0, errors = 0;

   typedef struct {
      logic v0, we0; logic [3:0] a0; logic [7:0] d0;
      logic v1, we1; logic [3:0] a1; logic [7:0] d1;
      logic g0, g1;
   } vec_t;
   vec_t tbl [17];

   bram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid_0(req_valid_0), .req_we_0(req_we_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
      .req_ready_0(req_ready_0), .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
      .req_valid_1(req_valid_1), .req_we_1(req_we_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
      .req_ready_1(req_ready_1), .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
      .init_done(init_done), .mem_rst(mem_rst), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_write_data(mem_write_data), .mem_rd_addr(mem_rd_addr), .mem_read_data(mem_read_data)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // registered-read RAM with synchronous reset of its output register
   always @(posedge clk)
      if (mem_rst) mem_read_data <= '0;
      else begin
         if (mem_wr_en) ram[mem_wr_addr] <= mem_write_data;
         mem_read_data <= ram[mem_rd_addr];
      end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (rst) begin
         if (rsp_valid_0) begin
            if (q0.size() == 0) chk("rsp_valid_0 unexpected", 1, 0);
            else chk("rsp_rdata_0", {24'd0, rsp_rdata_0}, {24'd0, q0.pop_front()});
         end else if (q0.size() != 0) begin
            chk("rsp_valid_0 missing", 0, 1);
            void'(q0.pop_front());
         end
         if (rsp_valid_1) begin
            if (q1.size() == 0) chk("rsp_valid_1 unexpected", 1, 0);
            else chk("rsp_rdata_1", {24'd0, rsp_rdata_1}, {24'd0, q1.pop_front()});
         end else if (q1.size() != 0) begin
            chk("rsp_valid_1 missing", 0, 1);
            void'(q1.pop_front());
         end
      end

   function automatic vec_t mk(logic v0, logic we0, logic [3:0] a0, logic [7:0] d0,
                               logic v1, logic we1, logic [3:0] a1, logic [7:0] d1,
                               logic g0, logic g1);
      vec_t v;
      v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      @(negedge clk);
      req_valid_0 = v.v0; req_we_0 = v.we0; req_addr_0 = v.a0; req_wdata_0 = v.d0;
      req_valid_1 = v.v1; req_we_1 = v.we1; req_addr_1 = v.a1; req_wdata_1 = v.d1;
      #1;
      chk("req_ready_0", {31'd0, req_ready_0}, {31'd0, v.g0});
      chk("req_ready_1", {31'd0, req_ready_1}, {31'd0, v.g1});
      // reads see the contents before any write of the same cycle
      if (v.g0 && !v.we0) q0.push_back(ref_mem[v.a0]);
      if (v.g1 && !v.we1) q1.push_back(ref_mem[v.a1]);
      if (v.g0 && v.we0) ref_mem[v.a0] = v.d0;
      if (v.g1 && v.we1) ref_mem[v.a1] = v.d1;
   endtask

   task automatic do_init();
      @(negedge clk);
      rst = 1;
      req_valid_0 = 1; req_we_0 = 0; req_addr_0 = 0;
      req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 0;
      #1;
      chk("hold mem_rst", {31'd0, mem_rst}, 1);
      chk("hold mem_wr_en", {31'd0, mem_wr_en}, 0);
      chk("hold ready", {30'd0, req_ready_1, req_ready_0}, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         #1;
         chk("init mem_wr_en", {31'd0, mem_wr_en}, 1);
         chk("init mem_wr_addr", {28'd0, mem_wr_addr}, i);
         chk("init mem_write_data", {24'd0, mem_write_data}, 0);
         chk("init mem_rst", {31'd0, mem_rst}, 0);
         chk("init ready", {30'd0, req_ready_1, req_ready_0}, 0);
         chk("init init_done", {31'd0, init_done}, 0);
      end
      @(negedge clk);
      req_valid_0 = 0; req_valid_1 = 0;
      #1;
      chk("run init_done", {31'd0, init_done}, 1);
      chk("run idle mem_wr_en", {31'd0, mem_wr_en}, 0);
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(1, 255));
      rst = 0;
      req_valid_0 = 0; req_we_0 = 0; req_addr_0 = 0; req_wdata_0 = 0;
      req_valid_1 = 0; req_we_1 = 0; req_addr_1 = 0; req_wdata_1 = 0;
      tbl[0]  = mk(1, 1, 3, 8'hA5, 0, 0, 0, 0,     1, 0);
      tbl[1]  = mk(0, 0, 0, 0,     1, 0, 3, 0,     0, 1);
      tbl[2]  = mk(0, 0, 0, 0,     1, 1, 2, 8'h5C, 0, 1);
      tbl[3]  = mk(1, 0, 3, 0,     1, 0, 2, 0,     1, 0);
      tbl[4]  = mk(1, 0, 3, 0,     1, 0, 2, 0,     0, 1);
      tbl[5]  = mk(1, 0, 3, 0,     1, 0, 2, 0,     1, 0);
      tbl[6]  = mk(1, 0, 3, 0,     1, 0, 2, 0,     0, 1);
      tbl[7]  = mk(1, 1, 7, 8'h11, 0, 0, 0, 0,     1, 0);
      tbl[8]  = mk(1, 1, 7, 8'h22, 1, 0, 7, 0,     1, 1);
      tbl[9]  = mk(0, 0, 0, 0,     1, 0, 7, 0,     0, 1);
      tbl[10] = mk(1, 0, 0, 0,     1, 0, 0, 0,     1, 0);
      tbl[11] = mk(1, 1, 5, 8'h01, 1, 1, 5, 8'h02, 0, 1);
      tbl[12] = mk(1, 1, 5, 8'h01, 0, 0, 0, 0,     1, 0);
      tbl[13] = mk(1, 0, 5, 0,     0, 0, 0, 0,     1, 0);
      tbl[14] = mk(1, 0, 9, 0,     1, 1, 9, 8'h33, 1, 1);
      tbl[15] = mk(1, 0, 9, 0,     0, 0, 0, 0,     1, 0);
      tbl[16] = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0);
      repeat (2) @(negedge clk);
      chk("reset mem_rst", {31'd0, mem_rst}, 1);
      chk("reset rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
      chk("reset init_done", {31'd0, init_done}, 0);
      chk("reset mem_wr_en", {31'd0, mem_wr_en}, 0);
      do_init();
      for (int i = 0; i < 16; i++) apply(mk(1, 0, 4'(i), 0, 0, 0, 0, 0, 1, 0));
      foreach (tbl[i]) apply(tbl[i]);
      repeat (2) apply(tbl[16]);
      chk("scoreboard drained", q0.size() + q1.size(), 0);
      apply(mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 0));
      @(posedge clk);
      #1;
      chk("pending before reset", {31'd0, rsp_valid_0}, 1);
      rst = 0;
      q0.delete(); q1.delete();
      #1;
      chk("async rsp_valid_0", {31'd0, rsp_valid_0}, 0);
      chk("async init_done", {31'd0, init_done}, 0);
      chk("async mem_rst", {31'd0, mem_rst}, 1);
      chk("async mem_wr_en", {31'd0, mem_wr_en}, 0);
      repeat (2) @(negedge clk);
      do_init();
      apply(mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 0));
      apply(mk(0, 0, 0, 0, 1, 0, 5, 0, 0, 1));
      repeat (2) apply(tbl[16]);
      chk("scoreboard drained", q0.size() + q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
